hit_judge: RTL

//  Consumes the bottom cell of one arrow column (the `next` output of the final light cell).

---
 rtl/hit_judge_if.sv | 26 ++
 rtl/hit_judge.sv | 106 ++++++++++
 2 files changed

// File: rtl/hit_judge_if.sv
// Column-judge bus: player key and bottom-cell presence in, judgement pulses and counters out.
interface hit_judge_if #(
  parameter int SCORE_W = 8,
  parameter int COMBO_W = 6,
  parameter int MISS_W  = 8
) ();
  logic               key;
  logic               last_light;
  logic               clear_out;
  logic               hit;
  logic               miss;
  logic               stray;
  logic [SCORE_W-1:0] score;
  logic [COMBO_W-1:0] combo;
  logic [MISS_W-1:0]  miss_count;

  modport master (
    output key, last_light,
    input  clear_out, hit, miss, stray, score, combo, miss_count
  );

  modport slave (
    input  key, last_light,
    output clear_out, hit, miss, stray, score, combo, miss_count
  );
endinterface

// File: rtl/hit_judge.sv
// Judges key presses against the bottom cell of one arrow column and keeps
// saturating score / combo / miss counters.
//
// state | meaning
// IDLE  | no note in bottom cell, or note already judged and gone
// ARMED | note present and not yet pressed; leaving now is a miss
// HIT   | note was hit; wait for the cell to empty before judging again
module hit_judge #(
  parameter int SCORE_W     = 8,
  parameter int COMBO_W     = 6,
  parameter int MISS_W      = 8,
  parameter int COMBO_BONUS = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  hit_judge_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARMED, HIT} state_t;

  state_t             state;
  logic               key_q;
  logic               press;
  logic               clear_r, hit_r, miss_r, stray_r;
  logic [SCORE_W-1:0] score_r;
  logic [COMBO_W-1:0] combo_r;
  logic [MISS_W-1:0]  miss_r_cnt;

  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_next;
  logic [COMBO_W-1:0] combo_next;
  logic [MISS_W-1:0]  miss_next;

  // Bonus is decided on the combo value before this hit increments it.
  always_comb begin
    press      = bus.key & ~key_q;
    score_sum  = {1'b0, score_r} +
                 ((combo_r >= COMBO_W'(COMBO_BONUS)) ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1));
    score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    combo_next = (&combo_r) ? combo_r : combo_r + 1'b1;
    miss_next  = (&miss_r_cnt) ? miss_r_cnt : miss_r_cnt + 1'b1;
  end

  always_ff @(posedge Clock) begin
    key_q <= bus.key;
    if (Reset) begin
      state      <= IDLE;
      clear_r    <= 1'b0;
      hit_r      <= 1'b0;
      miss_r     <= 1'b0;
      stray_r    <= 1'b0;
      score_r    <= '0;
      combo_r    <= '0;
      miss_r_cnt <= '0;
    end else begin
      clear_r <= 1'b0;
      hit_r   <= 1'b0;
      miss_r  <= 1'b0;
      stray_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.last_light && press) begin
            clear_r <= 1'b1;
            hit_r   <= 1'b1;
            score_r <= score_next;
            combo_r <= combo_next;
            state   <= HIT;
          end else if (bus.last_light) begin
            state <= ARMED;
          end else if (press) begin
            stray_r <= 1'b1;
            combo_r <= '0;
          end
        end
        ARMED: begin
          // A press on the same edge the note drops out still counts as a hit.
          if (press) begin
            clear_r <= 1'b1;
            hit_r   <= 1'b1;
            score_r <= score_next;
            combo_r <= combo_next;
            state   <= HIT;
          end else if (!bus.last_light) begin
            miss_r     <= 1'b1;
            combo_r    <= '0;
            miss_r_cnt <= miss_next;
            state      <= IDLE;
          end
        end
        HIT: begin
          if (!bus.last_light) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.clear_out  = clear_r;
  assign bus.hit        = hit_r;
  assign bus.miss       = miss_r;
  assign bus.stray      = stray_r;
  assign bus.score      = score_r;
  assign bus.combo      = combo_r;
  assign bus.miss_count = miss_r_cnt;

endmodule
